// File: rtl/y86_pkg.sv
// ---------------------------------------------------------------------------
// y86_pkg
// Shared constants for the 64-bit Y86 pipeline: status codes, special
// register ids, instruction codes, the write-back state type and a helper
// that maps any non-AOK memory-stage status onto an architectural fault code.
// No ports.
// ---------------------------------------------------------------------------
package y86_pkg;

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_ADR = 3'd2;
   localparam logic [2:0] STAT_INS = 3'd3;
   localparam logic [2:0] STAT_HLT = 3'd4;

   localparam logic [3:0] REG_NONE = 4'hF;
   localparam logic [3:0] REG_RSP  = 4'h4;

   localparam logic [3:0] IHALT   = 4'd0;
   localparam logic [3:0] INOP    = 4'd1;
   localparam logic [3:0] IRRMOVQ = 4'd2;
   localparam logic [3:0] IIRMOVQ = 4'd3;
   localparam logic [3:0] IRMMOVQ = 4'd4;
   localparam logic [3:0] IMRMOVQ = 4'd5;
   localparam logic [3:0] IOPQ    = 4'd6;
   localparam logic [3:0] IJXX    = 4'd7;
   localparam logic [3:0] ICALL   = 4'd8;
   localparam logic [3:0] IRET    = 4'd9;
   localparam logic [3:0] IPUSHQ  = 4'd10;
   localparam logic [3:0] IPOPQ   = 4'd11;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } wb_state_e;

   // ADR/INS/HLT pass through; codes with no architectural meaning
   // (0, 5, 6, 7) are reported as an invalid instruction.
   function automatic logic [2:0] fault_stat(input logic [2:0] s);
      if (s == STAT_ADR || s == STAT_INS || s == STAT_HLT)
         return s;
      return STAT_INS;
   endfunction

endpackage

// File: rtl/y86_regfile.sv
// ---------------------------------------------------------------------------
// y86_regfile
// NREGS x DATA_W architectural register file with two write ports (E, M)
// and two combinational read ports (A, B).
// Optional feature macro: WB_RF_BYPASS_EN -- when defined, a read of a
// register being written this cycle returns the incoming data.
//
// Ports:
//   clk, rst_n    rising-edge clock, synchronous active-low reset
//   we            commit enable for both write ports this cycle
//   dstE, valE    write port E (id 15 = no write)
//   dstM, valM    write port M (id 15 = no write); M wins over E
//   srcA, srcB    read addresses (id 15 reads as 0)
//   valA, valB    read data
// ---------------------------------------------------------------------------
module y86_regfile
   import y86_pkg::*;
#(
   parameter int                DATA_W   = 64,
   parameter int                NREGS    = 15,
   parameter logic [DATA_W-1:0] RSP_INIT = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [3:0]        dstE,
   input  logic [DATA_W-1:0] valE,
   input  logic [3:0]        dstM,
   input  logic [DATA_W-1:0] valM,
   input  logic [3:0]        srcA,
   input  logic [3:0]        srcB,
   output logic [DATA_W-1:0] valA,
   output logic [DATA_W-1:0] valB
);

   logic [DATA_W-1:0] regs [NREGS];

   // Ids only ever match indices 0..NREGS-1, so REG_NONE never writes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++)
            regs[i] <= (4'(i) == REG_RSP) ? RSP_INIT : '0;
      end else if (we) begin
         for (int i = 0; i < NREGS; i++) begin
            if (dstM == 4'(i))
               regs[i] <= valM;          // popq %rsp: memory value wins
            else if (dstE == 4'(i))
               regs[i] <= valE;
         end
      end
   end

   always_comb begin
      valA = '0;
      valB = '0;
      for (int i = 0; i < NREGS; i++) begin
         if (srcA == 4'(i)) valA = regs[i];
         if (srcB == 4'(i)) valB = regs[i];
      end
`ifdef WB_RF_BYPASS_EN
      if (we) begin
         if (srcA != REG_NONE) begin
            if (srcA == dstM)      valA = valM;
            else if (srcA == dstE) valA = valE;
         end
         if (srcB != REG_NONE) begin
            if (srcB == dstM)      valB = valM;
            else if (srcB == dstE) valB = valE;
         end
      end
`endif
   end

endmodule

// File: rtl/writeback_regfile.sv
// ---------------------------------------------------------------------------
// writeback_regfile
// Y86-64 write-back stage: commits valE/valM into the register file, keeps
// the sticky processor status, the RUN/HALTED state and the count of
// retired AOK instructions. Decode reads through valA/valB.
// Optional feature macro: WB_RF_BYPASS_EN (same-cycle write-to-read bypass).
//
// Ports:
//   clk, rst_n    rising-edge clock, synchronous active-low reset
//   icode         instruction code in write-back (informational only)
//   stat_in       memory-stage status (1 AOK, 2 ADR, 3 INS, 4 HLT)
//   valE, dstE    ALU result and its destination (15 = none)
//   valM, dstM    memory data and its destination (15 = none)
//   srcA, srcB    decode read addresses
//   valA, valB    decode read data
//   stat          architectural status
//   halted        high in the HALTED state (direct view of the FSM state)
//   retired       committed AOK instruction count, wraps
// ---------------------------------------------------------------------------
module writeback_regfile
   import y86_pkg::*;
#(
   parameter int                DATA_W   = 64,
   parameter int                NREGS    = 15,
   parameter logic [DATA_W-1:0] RSP_INIT = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3:0]        icode,
   input  logic [2:0]        stat_in,
   input  logic [DATA_W-1:0] valE,
   input  logic [DATA_W-1:0] valM,
   input  logic [3:0]        dstE,
   input  logic [3:0]        dstM,
   input  logic [3:0]        srcA,
   input  logic [3:0]        srcB,
   output logic [DATA_W-1:0] valA,
   output logic [DATA_W-1:0] valB,
   output logic [2:0]        stat,
   output logic              halted,
   output logic [DATA_W-1:0] retired
);

   wb_state_e         state_q, state_d;
   logic [2:0]        stat_q, stat_d;
   logic [DATA_W-1:0] retired_q, retired_d;
   logic              commit;

   // The halt path (icode = IHALT with HLT status) needs no special
   // handling here; icode is carried for trace visibility only.
   logic unused_icode;
   assign unused_icode = ^icode;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_RUN;
         stat_q    <= STAT_AOK;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         stat_q    <= stat_d;
         retired_q <= retired_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      stat_d    = stat_q;
      retired_d = retired_q;
      commit    = 1'b0;
      if (state_q == ST_RUN) begin
         if (stat_in == STAT_AOK) begin
            commit    = 1'b1;
            retired_d = retired_q + DATA_W'(1);
         end else begin
            stat_d  = fault_stat(stat_in);
            state_d = ST_HALTED;
         end
      end
   end

   assign stat    = stat_q;
   assign halted  = (state_q == ST_HALTED);
   assign retired = retired_q;

   y86_regfile #(
      .DATA_W   (DATA_W),
      .NREGS    (NREGS),
      .RSP_INIT (RSP_INIT)
   ) u_regfile (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (commit),
      .dstE  (dstE),
      .valE  (valE),
      .dstM  (dstM),
      .valM  (valM),
      .srcA  (srcA),
      .srcB  (srcB),
      .valA  (valA),
      .valB  (valB)
   );

endmodule

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
- Write-back stage of the 64-bit Y86 processor, directly downstream of the data-memory stage.
- Consumes valE, valM, dstE, dstM and the memory-stage status, then commits results into the 15-entry architectural register file.
- Provides the combinational read ports used by decode.
- Owns the sticky processor status and halt state machine, plus a retired-instruction counter.

Parameters:
- DATA_W, 64, register/data width
- NREGS, 15, architectural registers (ids 0..14; id 15 = RNONE)
- RSP_INIT, 0, reset value of register 4 (%rsp)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- icode  input  4  instruction code of the instruction in write-back
- stat_in  input  3  status from memory stage (1 AOK, 2 ADR, 3 INS, 4 HLT)
- valE  input  DATA_W  ALU result
- valM  input  DATA_W  memory read data
- dstE  input  4  destination for valE (15 = none)
- dstM  input  4  destination for valM (15 = none)
- srcA  input  4  decode read address A
- srcB  input  4  decode read address B
- valA  output  DATA_W  register[srcA]; 0 when srcA = 15
- valB  output  DATA_W  register[srcB]; 0 when srcB = 15
- stat  output  3  architectural processor status
- halted  output  1  high once in HALTED state
- retired  output  DATA_W  count of committed AOK instructions

Behaviour:
- Reset:
  - Sampled on rising clk while rst_n = 0.
  - All registers clear to 0, except reg 4, which loads RSP_INIT.
  - stat = 1 (AOK), halted = 0, retired = 0, state = RUN.
  - Reset asserted mid-operation, including from HALTED, takes effect at the next edge unconditionally.
- State machine: two states, RUN and HALTED.
  - RUN, stat_in = 1:
    - If dstE != 15, write valE to reg[dstE].
    - If dstM != 15, write valM to reg[dstM].
    - retired += 1, wrapping modulo 2^DATA_W.
    - Stay in RUN.
  - RUN, stat_in in {2, 3, 4}:
    - No register writes; retired is unchanged.
    - stat <= stat_in, halted <= 1, next state HALTED.
    - icode = 0 with stat_in = 4 is the normal halt path.
  - RUN, stat_in in {0, 5, 6, 7} (illegal): treated as INS; stat <= 3, then HALTED.
  - HALTED: all writes, counter and stat are frozen; exit only by reset.
- Write conflict: dstE = dstM != 15 in the same cycle → valM wins (popq %rsp semantics).
- Write latency: one cycle. A write at edge N is visible on valA/valB after edge N.
- Reads: combinational from the register array.
  - srcX = 15 returns 0.
  - A same-cycle read of a register being written returns the old value (see optional feature).
- Width rules: register ids are 4 bits; id 15 is never stored. The array holds exactly NREGS entries.

Optional Feature:
- Macro: WB_RF_BYPASS_EN.
- When defined: a read whose srcX matches a register being written this cycle returns the incoming data instead of the old value. valM takes priority over valE, matching the conflict rule. The bypass applies only in RUN with stat_in = 1.
- When undefined: reads always return the stored array contents (old value).

Decomposition:
- Shared package y86_pkg:
  - Stat codes STAT_AOK = 1, STAT_ADR = 2, STAT_INS = 3, STAT_HLT = 4.
  - REG_NONE = 4'hF, REG_RSP = 4'h4.
  - icode constants (IHALT = 0 … IPOPQ = 11).
- Sub-module y86_regfile: 15×DATA_W array, two write ports, two read ports, optional bypass.
- The top level holds the RUN/HALTED state machine, the stat register and the retired counter.

Test Plan:
- Reset with RSP_INIT = 0x2000 → reg4 = 0x2000, all others 0, stat = 1, halted = 0, retired = 0.
- stat_in = 1, dstE = 2, valE = 0x55, dstM = 15 → the next cycle srcA = 2 gives valA = 0x55, retired = 1.
- dstE = dstM = 4, valE = 0x100, valM = 0x200, stat_in = 1 → reg4 = 0x200.
- stat_in = 2 with dstE = 3, valE = 0x99 → reg3 unchanged, stat = 2, halted = 1. Later AOK inputs with writes leave registers, stat and retired frozen.
- icode = 0, stat_in = 4 → stat = 4, halted = 1. Then rst_n = 0 for one edge → stat = 1, halted = 0, registers reset.
- With WB_RF_BYPASS_EN: dstE = 5, valE = 0x7, srcB = 5 in the same cycle → valB = 0x7 combinationally. Without the macro → valB shows the old value, 0.
